ysyx_22040237_ifu: RTL and testbench

- Instruction fetch unit for the single-cycle core; the producer end of the pc/inst interface that the decode unit consumes.
- Owns the PC register and issues word fetches on a valid/ready instruction-memory port.
- Presents {pc, inst} to decode with a valid/ready handshake.
- Takes the jump redirect (flag plus two addends) back from decode and restarts fetch at the target, discarding any in-flight response.

---
 rtl/ysyx_22040237_ifu_if.sv | 44 ++++
 rtl/ysyx_22040237_ifu.sv | 125 ++++++++++++
 tb/tb_ysyx_22040237_ifu.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_22040237_ifu_if.sv
// Fetch-unit bus bundle: instruction-memory port, decode handshake and jump redirect.
// YSYX_22040237_IFU_MISALIGN_CHK_EN adds the if_misalign trap flag.
interface ysyx_22040237_ifu_if #(
  parameter int unsigned PC_W = 32
);
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [PC_W-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [31:0]     imem_rsp_data;
  logic            if_valid;
  logic            if_ready;
  logic [PC_W-1:0] if_pc;
  logic [31:0]     if_inst;
  logic            redir_valid;
  logic [PC_W-1:0] redir_op1;
  logic [PC_W-1:0] redir_op2;
  logic            redir_jalr;
`ifdef YSYX_22040237_IFU_MISALIGN_CHK_EN
  logic            if_misalign;
`endif

  // Fetch unit side
  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
    output if_valid, if_pc, if_inst,
    input  if_ready, redir_valid, redir_op1, redir_op2, redir_jalr
`ifdef YSYX_22040237_IFU_MISALIGN_CHK_EN
    , output if_misalign
`endif
  );

  // Memory / decode side
  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data,
    input  if_valid, if_pc, if_inst,
    output if_ready, redir_valid, redir_op1, redir_op2, redir_jalr
`ifdef YSYX_22040237_IFU_MISALIGN_CHK_EN
    , input if_misalign
`endif
  );
endinterface

// File: rtl/ysyx_22040237_ifu.sv
// Instruction fetch unit: owns the PC, fetches one word at a time, presents {pc, inst} to decode.
// YSYX_22040237_IFU_MISALIGN_CHK_EN traps on redirect targets with bit 1 set.
module ysyx_22040237_ifu #(
  parameter int unsigned     PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = PC_W'(32'h8000_0000)
) (
  input logic                clk,
  input logic                rst_n,
  ysyx_22040237_ifu_if.master bus
);
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_TRAP} state_e;

  state_e          state_q;
  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] if_pc_q;
  logic [31:0]     if_inst_q;
  logic            drop_q;
  logic            req_valid_q;
  logic            if_valid_q;
  logic [PC_W-1:0] target;
  logic            redir;

  // Jump target: modular sum, bit 0 cleared for jalr
  always_comb begin
    target = bus.redir_op1 + bus.redir_op2;
    if (bus.redir_jalr) target[0] = 1'b0;
  end

  assign redir = bus.redir_valid;

`ifdef YSYX_22040237_IFU_MISALIGN_CHK_EN
  logic misalign_q;
  logic trap_c;
  assign trap_c          = redir & target[1] & (state_q != S_TRAP);
  assign bus.if_misalign = misalign_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      misalign_q <= 1'b0;
    else if (trap_c) misalign_q <= 1'b1;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_REQ;
      pc_q        <= RESET_PC;
      drop_q      <= 1'b0;
      req_valid_q <= 1'b0;
      if_valid_q  <= 1'b0;
      if_pc_q     <= RESET_PC;
      if_inst_q   <= NOP;
    end else
`ifdef YSYX_22040237_IFU_MISALIGN_CHK_EN
    // A misaligned target is never fetched; the trap is presented until reset
    if (trap_c) begin
      state_q     <= S_TRAP;
      req_valid_q <= 1'b0;
      if_valid_q  <= 1'b1;
      if_pc_q     <= target;
      if_inst_q   <= NOP;
    end else
`endif
    begin
      case (state_q)
        S_REQ: begin
          if (req_valid_q && bus.imem_req_ready) begin
            req_valid_q <= 1'b0;
            state_q     <= S_WAIT;
            if (redir) begin
              pc_q   <= target;
              drop_q <= 1'b1;
            end
          end else begin
            req_valid_q <= 1'b1;
            if (redir) pc_q <= target;
          end
        end
        S_WAIT: begin
          if (bus.imem_rsp_valid) begin
            // Stale response (redirect already taken or arriving now) is discarded
            if (drop_q || redir) begin
              drop_q      <= 1'b0;
              state_q     <= S_REQ;
              req_valid_q <= 1'b1;
              if (redir) pc_q <= target;
            end else begin
              if_inst_q  <= bus.imem_rsp_data;
              if_pc_q    <= pc_q;
              if_valid_q <= 1'b1;
              state_q    <= S_HOLD;
            end
          end else if (redir) begin
            pc_q   <= target;
            drop_q <= 1'b1;
          end
        end
        S_HOLD: begin
          if (redir) begin
            if_valid_q  <= 1'b0;
            pc_q        <= target;
            state_q     <= S_REQ;
            req_valid_q <= 1'b1;
          end else if (bus.if_ready) begin
            if_valid_q  <= 1'b0;
            pc_q        <= pc_q + PC_W'(4);
            state_q     <= S_REQ;
            req_valid_q <= 1'b1;
          end
        end
`ifdef YSYX_22040237_IFU_MISALIGN_CHK_EN
        S_TRAP: ;
`endif
        default: state_q <= S_REQ;
      endcase
    end
  end

  assign bus.imem_req_valid = req_valid_q;
  assign bus.imem_req_addr  = pc_q;
  assign bus.if_valid       = if_valid_q;
  assign bus.if_pc          = if_pc_q;
  assign bus.if_inst        = if_inst_q;
endmodule

// File: tb/tb_ysyx_22040237_ifu.sv
// Bench for ysyx_22040237_ifu: directed fetch/redirect/reset steps plus random traffic
// against an instruction-stream model (expected PC sequence + address-hashed memory).
module tb_ysyx_22040237_ifu;
  localparam logic [31:0] RESET_PC = 32'h8000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst_n;

  ysyx_22040237_ifu_if #(.PC_W(32)) bus ();
  ysyx_22040237_ifu #(.PC_W(32), .RESET_PC(RESET_PC)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int consumed = 0;
  bit mem_ready, dec_ready, rv, rjalr, lat_rand, prev_hold;
  int mem_lat;
  logic [31:0] rop1, rop2, exp_pc, prev_pc, prev_inst;
  int due_q[$];
  logic [31:0] dat_q[$];

  function automatic logic [31:0] mem_word(logic [31:0] a);
    if (a == RESET_PC) return 32'h0010_0093;
    return (a * 32'h9E37_79B1) ^ 32'h3C6E_F372;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One cycle: drive inputs at the falling edge, update the model, advance
  task automatic step();
    logic [31:0] tgt;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = $urandom;
    if (due_q.size() > 0 && due_q[0] <= cyc) begin
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = dat_q[0];
      void'(due_q.pop_front());
      void'(dat_q.pop_front());
    end
    bus.imem_req_ready = mem_ready;
    bus.if_ready       = dec_ready;
    bus.redir_valid    = rv;
    bus.redir_op1      = rop1;
    bus.redir_op2      = rop2;
    bus.redir_jalr     = rjalr;
    tgt = rop1 + rop2;
    if (rjalr) tgt[0] = 1'b0;
    if (rst_n) begin
      if (prev_hold) begin
        chk("hold_valid", 32'(bus.if_valid), 32'd1);
        chk("hold_pc", bus.if_pc, prev_pc);
        chk("hold_inst", bus.if_inst, prev_inst);
      end
      chk("no_prefetch", 32'(bus.imem_req_valid & bus.if_valid), 32'd0);
      if (bus.imem_req_valid && mem_ready) begin
        chk("req_addr", bus.imem_req_addr, exp_pc);
        due_q.push_back(cyc + (lat_rand ? int'($urandom_range(1, 4)) : mem_lat));
        dat_q.push_back(mem_word(bus.imem_req_addr));
      end
      if (bus.if_valid && dec_ready) begin
        chk("consume_pc", bus.if_pc, exp_pc);
        chk("consume_inst", bus.if_inst, mem_word(exp_pc));
        consumed++;
        if (!rv) exp_pc = exp_pc + 32'd4;
      end
      prev_hold = bus.if_valid && !dec_ready && !rv;
      prev_pc   = bus.if_pc;
      prev_inst = bus.if_inst;
      if (rv) exp_pc = tgt;
    end else begin
      prev_hold = 1'b0;
    end
    rv = 1'b0;
    @(negedge clk);
    cyc++;
  endtask

  task automatic wait_if(string tag, int budget);
    int n = 0;
    while (bus.if_valid !== 1'b1 && n < budget) begin
      step();
      n++;
    end
    chk(tag, 32'(bus.if_valid), 32'd1);
  endtask

  task automatic wait_req(string tag, int budget);
    int n = 0;
    while (bus.imem_req_valid !== 1'b1 && n < budget) begin
      step();
      n++;
    end
    chk(tag, 32'(bus.imem_req_valid), 32'd1);
  endtask

  task automatic restart();
    rst_n     = 1'b1;
    exp_pc    = RESET_PC;
    prev_hold = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    int c0;
    bit seen;
    rst_n = 1'b0; mem_ready = 1'b1; dec_ready = 1'b0; rv = 1'b0; rjalr = 1'b0;
    rop1 = '0; rop2 = '0; mem_lat = 1; lat_rand = 1'b0; exp_pc = RESET_PC; prev_hold = 1'b0;
    prev_pc = '0; prev_inst = '0;
    bus.imem_req_ready = 1'b0; bus.imem_rsp_valid = 1'b0; bus.imem_rsp_data = '0;
    bus.if_ready = 1'b0; bus.redir_valid = 1'b0; bus.redir_op1 = '0; bus.redir_op2 = '0;
    bus.redir_jalr = 1'b0;
    repeat (3) @(negedge clk);

    chk("rst_if_valid", 32'(bus.if_valid), 32'd0);
    chk("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
    chk("rst_if_pc", bus.if_pc, RESET_PC);
    chk("rst_if_inst", bus.if_inst, NOP);
`ifdef YSYX_22040237_IFU_MISALIGN_CHK_EN
    chk("rst_misalign", 32'(bus.if_misalign), 32'd0);
`endif

    restart();
    step();
    chk("first_req_valid", 32'(bus.imem_req_valid), 32'd1);
    chk("first_req_addr", bus.imem_req_addr, RESET_PC);
    wait_if("first_present", 10);
    chk("first_if_pc", bus.if_pc, RESET_PC);
    chk("first_if_inst", bus.if_inst, 32'h0010_0093);

    repeat (5) step();
    chk("stall_valid", 32'(bus.if_valid), 32'd1);
    chk("stall_pc", bus.if_pc, RESET_PC);
    dec_ready = 1'b1; step(); dec_ready = 1'b0;
    wait_req("seq_req", 10);
    chk("seq_addr", bus.imem_req_addr, 32'h8000_0004);

    // jal while presenting, consumed the same cycle
    wait_if("jal_present", 10);
    dec_ready = 1'b1; rv = 1'b1; rop1 = 32'h8000_0008; rop2 = 32'h0000_0010; rjalr = 1'b0;
    step(); dec_ready = 1'b0;
    wait_req("jal_req", 10);
    chk("jal_addr", bus.imem_req_addr, 32'h8000_0018);

    // Redirect while the response is outstanding; stale data must not surface
    mem_lat = 3; step();
    rv = 1'b1; rop1 = 32'h8000_0100; rop2 = 32'hFFFF_FFFC; rjalr = 1'b1;
    step(); mem_lat = 1;
    seen = 1'b0;
    for (int n = 0; n < 10 && bus.imem_req_valid !== 1'b1; n++) begin
      if (bus.if_valid) seen = 1'b1;
      step();
    end
    chk("stale_hidden", 32'(seen), 32'd0);
    chk("stale_req", 32'(bus.imem_req_valid), 32'd1);
    chk("wait_redir_addr", bus.imem_req_addr, 32'h8000_00FC);
    wait_if("wait_redir_present", 10);
    chk("wait_redir_pc", bus.if_pc, 32'h8000_00FC);
    chk("wait_redir_inst", bus.if_inst, mem_word(32'h8000_00FC));

    // jalr to 8000_0203: bit 0 cleared, bit 1 left set
    dec_ready = 1'b1; rv = 1'b1; rop1 = 32'h8000_0200; rop2 = 32'h0000_0003; rjalr = 1'b1;
    step(); dec_ready = 1'b0;
`ifdef YSYX_22040237_IFU_MISALIGN_CHK_EN
    chk("trap_valid", 32'(bus.if_valid), 32'd1);
    chk("trap_pc", bus.if_pc, 32'h8000_0202);
    chk("trap_inst", bus.if_inst, NOP);
    chk("trap_misalign", 32'(bus.if_misalign), 32'd1);
    repeat (4) step();
    chk("trap_no_req", 32'(bus.imem_req_valid), 32'd0);
    chk("trap_held", 32'(bus.if_misalign), 32'd1);
    rst_n = 1'b0; step(); step();
    due_q.delete(); dat_q.delete();
    restart();
`else
    wait_req("jalr_req", 10);
    chk("jalr_addr", bus.imem_req_addr, 32'h8000_0202);
    wait_if("jalr_present", 10);
    dec_ready = 1'b1; step(); dec_ready = 1'b0;
`endif

    // Random traffic against the stream model
    lat_rand = 1'b1;
    c0 = consumed;
    for (int i = 0; i < 600; i++) begin
      mem_ready = ($urandom_range(0, 3) != 0);
      dec_ready = ($urandom_range(0, 1) != 0);
      if ($urandom_range(0, 7) == 0) begin
        rv    = 1'b1;
        rjalr = ($urandom_range(0, 1) != 0);
        rop1  = RESET_PC + 32'($urandom_range(0, 255) * 4);
        rop2  = 32'(($urandom_range(0, 63) - 32) * 4) + (rjalr ? 32'd1 : 32'd0);
      end
      step();
    end
    lat_rand = 1'b0; dec_ready = 1'b0; mem_ready = 1'b1;
    chk("rand_progress", 32'((consumed - c0) > 10), 32'd1);

    // Reset while waiting on memory; the late response must be ignored
    wait_req("rstw_req", 20);
    mem_lat = 4; step();
    mem_ready = 1'b0;
    rst_n = 1'b0; #1;
    chk("rstw_if_valid", 32'(bus.if_valid), 32'd0);
    chk("rstw_req_valid", 32'(bus.imem_req_valid), 32'd0);
    step();
    restart();
    seen = 1'b0;
    for (int n = 0; n < 10 && due_q.size() > 0; n++) begin
      if (bus.if_valid) seen = 1'b1;
      step();
    end
    step();
    chk("rstw_late_hidden", 32'(seen | bus.if_valid), 32'd0);
    mem_ready = 1'b1; mem_lat = 1;
    wait_req("rstw_restart", 10);
    chk("rstw_addr", bus.imem_req_addr, RESET_PC);
    wait_if("rstw_present", 10);
    chk("rstw_inst", bus.if_inst, 32'h0010_0093);

    // Reset while presenting to decode
    repeat (2) step();
    rst_n = 1'b0; #1;
    chk("rsth_if_valid", 32'(bus.if_valid), 32'd0);
    chk("rsth_req_valid", 32'(bus.imem_req_valid), 32'd0);
    chk("rsth_if_pc", bus.if_pc, RESET_PC);
    step();
    restart();
    wait_req("rsth_restart", 10);
    chk("rsth_addr", bus.imem_req_addr, RESET_PC);
    wait_if("rsth_present", 10);
    chk("rsth_pc", bus.if_pc, RESET_PC);
    dec_ready = 1'b1; step(); dec_ready = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
